// File: rtl/tabla_pkg.sv
// Shared types and sizes for the tabla_barrido truth-table sweeper.
// Optional capture of the reference truth table is enabled with CAPTURA_TABLA_EN.
package tabla_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam int NUM_VEC = 32;
  localparam int VEC_W   = 5;
  localparam int CNT_W   = 6;
  localparam int HOLD_W  = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = 5'd31;

  // Mismatch count stops at NUM_VEC instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v >= CNT_W'(NUM_VEC)) begin
      r = v;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Down-counter that times the settle interval of each stimulus vector.
// tc is high while the count is zero; load takes priority over enable.
module contador_espera
  import tabla_pkg::*;
#(
  parameter int W = HOLD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Settle counter register: load, count down to zero, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/tabla_barrido.sv
// Sweeps all 32 input vectors, holds each HOLD_CYC cycles, then compares f_ref
// against f_min and records mismatches. Define CAPTURA_TABLA_EN to add the tabla output.
module tabla_barrido
  import tabla_pkg::*;
#(
  parameter int HOLD_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [VEC_W-1:0]   vec,
  input  logic               f_ref,
  input  logic               f_min,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [VEC_W-1:0]   first_err,
  output logic               first_err_vld
`ifdef CAPTURA_TABLA_EN
  ,
  output logic [NUM_VEC-1:0] tabla
`endif
);

  // The counter reaches terminal count after HOLD_CYC SETTLE cycles.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  state_t state;
  state_t state_nx;
  logic   cnt_load;
  logic   cnt_en;
  logic   cnt_tc;
  logic   sweep_clr;
  logic   check_now;
  logic   vec_inc;

  contador_espera #(
    .W(HOLD_W)
  ) u_espera (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .enable  (cnt_en),
    .load_val(HOLD_LOAD),
    .tc      (cnt_tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    sweep_clr = 1'b0;
    check_now = 1'b0;
    vec_inc   = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          state_nx  = SETTLE;
          cnt_load  = 1'b1;
          sweep_clr = 1'b1;
        end else begin
          state_nx  = state;
        end
      end
      SETTLE: begin
        if (cnt_tc) begin
          state_nx = CHECK;
        end else begin
          cnt_en   = 1'b1;
        end
      end
      CHECK: begin
        check_now = 1'b1;
        if (vec == VEC_LAST) begin
          state_nx = FIN;
        end else begin
          state_nx = SETTLE;
          cnt_load = 1'b1;
          vec_inc  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Stimulus vector, mismatch bookkeeping and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec           <= '0;
      err_cnt       <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (sweep_clr) begin
        vec           <= '0;
        err_cnt       <= '0;
        first_err     <= '0;
        first_err_vld <= 1'b0;
      end else begin
        if (check_now && (f_ref != f_min)) begin
          err_cnt <= sat_inc(err_cnt);
          if (!first_err_vld) begin
            first_err     <= vec;
            first_err_vld <= 1'b1;
          end else begin
            first_err     <= first_err;
            first_err_vld <= first_err_vld;
          end
        end else begin
          err_cnt       <= err_cnt;
          first_err     <= first_err;
          first_err_vld <= first_err_vld;
        end
        if (vec_inc) begin
          vec <= vec + 5'd1;
        end else begin
          vec <= vec;
        end
      end
      busy <= (state_nx == SETTLE) || (state_nx == CHECK);
      done <= (state_nx == FIN);
    end
  end

`ifdef CAPTURA_TABLA_EN
  // Captured reference truth table, one bit per vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      tabla <= '0;
    end else if (sweep_clr) begin
      tabla <= '0;
    end else if (check_now) begin
      tabla[vec] <= f_ref;
    end else begin
      tabla <= tabla;
    end
  end
`endif

endmodule

// File: tb/tb_tabla_barrido.sv
// Self-checking bench for tabla_barrido: random truth tables and mismatch masks
// checked against a per-vector reference model. CAPTURA_TABLA_EN also checks tabla.
module tb_tabla_barrido;

  localparam int HOLD      = 2;
  localparam int SWEEP_CYC = 32 * (HOLD + 1);

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  vec;
  logic        f_ref;
  logic        f_min;
  logic        busy;
  logic        done;
  logic [5:0]  err_cnt;
  logic [4:0]  first_err;
  logic        first_err_vld;
  logic [31:0] tabla;

  logic [31:0] ref_tt;
  logic [31:0] mis;
  int          checks;
  int          errors;

  // Functions under test: f_ref from a truth table, f_min deviates where mis is set.
  assign f_ref = ref_tt[vec];
  assign f_min = ref_tt[vec] ^ mis[vec];

  tabla_barrido #(
    .HOLD_CYC(HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .vec          (vec),
    .f_ref        (f_ref),
    .f_min        (f_min),
    .busy         (busy),
    .done         (done),
    .err_cnt      (err_cnt),
    .first_err    (first_err),
    .first_err_vld(first_err_vld)
`ifdef CAPTURA_TABLA_EN
    ,
    .tabla        (tabla)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sweep; expectations come from counting the mismatch mask.
  task automatic run_sweep(input logic [31:0] tt, input logic [31:0] mask, input bit mid_start);
    int cycles;
    int exp_err;
    int exp_first;
    bit pulsed;
    ref_tt    = tt;
    mis       = mask;
    exp_err   = $countones(mask);
    exp_first = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) exp_first = i;
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_vec", {27'd0, vec}, 32'd0);
    chk("start_err_clr", {26'd0, err_cnt}, 32'd0);
    chk("start_vld_clr", {31'd0, first_err_vld}, 32'd0);
    cycles = 0;
    pulsed = 1'b0;
    while (done !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (mid_start && !pulsed && vec == 5'd5) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    if (mid_start) chk("mid_start_issued", {31'd0, pulsed}, 32'd1);
    chk("done_latency", cycles, SWEEP_CYC);
    chk("end_err_cnt", {26'd0, err_cnt}, exp_err);
    chk("end_first_err", {27'd0, first_err}, exp_first);
    chk("end_first_vld", {31'd0, first_err_vld}, {31'd0, (mask != 32'd0)});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_vec", {27'd0, vec}, 32'd31);
`ifdef CAPTURA_TABLA_EN
    chk("end_tabla", tabla, tt);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("fin_done_hold", {31'd0, done}, 32'd1);
    chk("fin_vec_nowrap", {27'd0, vec}, 32'd31);
  endtask

  initial begin
    int cycles;
    checks = 0;
    errors = 0;
    ref_tt = 32'd0;
    mis    = 32'd0;
    reset  = 1'b1;
    start  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", {27'd0, vec}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {26'd0, err_cnt}, 32'd0);
    chk("rst_first", {27'd0, first_err}, 32'd0);
    chk("rst_vld", {31'd0, first_err_vld}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_sweep($urandom, 32'd0, 1'b0);
    run_sweep($urandom, 32'h0000_2000, 1'b0);
    run_sweep($urandom, 32'hFFFF_FFFF, 1'b0);
    run_sweep($urandom, $urandom & $urandom & $urandom, 1'b0);
    run_sweep($urandom, $urandom, 1'b1);
    run_sweep(32'h0000_0020, 32'd0, 1'b0);

    // Reset in the middle of a sweep discards all progress.
    ref_tt = $urandom;
    mis    = 32'h0000_00FF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 0;
    while (vec !== 5'd10 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("wait_vec10", {27'd0, vec}, 32'd10);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_err", {26'd0, err_cnt}, 32'd8);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("mid_rst_vec", {27'd0, vec}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {26'd0, err_cnt}, 32'd0);
    chk("mid_rst_vld", {31'd0, first_err_vld}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_idle_vec", {27'd0, vec}, 32'd0);

    run_sweep($urandom, $urandom & $urandom, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
